// File: rtl/alu_issue_seq.sv
// Issue/sequencer stage for the 8-bit ALU: decodes instructions, reads an 8x8 register file,
// drives registered ALU operands and writes results back. Optional macro: ALU_SEQ_PERF_EN.
module alu_issue_seq #(
    parameter logic [7:0] REG_INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [2:0]  alu_opcode,
    output logic [7:0]  alu_op1,
    output logic [7:0]  alu_op2,
    input  logic [15:0] alu_result,
    input  logic        alu_flagC,
    input  logic        alu_flagZ,
    output logic        flag_c,
    output logic        flag_z,
    output logic        done,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data,
    output logic [15:0] perf_count
);

    // Handshake: an instruction transfers on a rising edge where instr_valid and instr_ready
    // are both high; instr_ready is high only in IDLE and does not depend on instr_valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WB_HI = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [7:0]  regs [8];
    logic [2:0]  rd_q;
    logic [7:0]  res_hi;
    logic        accept;
    logic        is_ldi;
    logic        is_mul;
    logic        carry_op;

    assign accept   = instr_valid && (state == IDLE);
    assign is_ldi   = instr[15];
    // alu_opcode still holds the in-flight opcode during EXEC
    assign is_mul   = (alu_opcode == 3'b010);
    assign carry_op = (alu_opcode == 3'b000) || (alu_opcode == 3'b001);
    assign dbg_data = regs[dbg_addr];

    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid && !is_ldi) next_state = EXEC;
            end
            EXEC:    next_state = is_mul ? WB_HI : IDLE;
            WB_HI:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= REG_INIT;
            alu_opcode <= 3'd0;
            alu_op1    <= 8'd0;
            alu_op2    <= 8'd0;
            flag_c     <= 1'b0;
            flag_z     <= 1'b0;
            done       <= 1'b0;
            rd_q       <= 3'd0;
            res_hi     <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_ldi) begin
                            regs[instr[14:12]] <= instr[7:0];
                            done               <= 1'b1;
                        end else begin
                            alu_opcode <= instr[14:12];
                            alu_op1    <= regs[instr[8:6]];
                            alu_op2    <= regs[instr[5:3]];
                            rd_q       <= instr[11:9];
                        end
                    end
                end
                EXEC: begin
                    regs[rd_q] <= alu_result[7:0];
                    res_hi     <= alu_result[15:8];
                    flag_z     <= alu_flagZ;
                    if (carry_op) flag_c <= alu_flagC;
                    if (!is_mul) done <= 1'b1;
                end
                WB_HI: begin
                    // high product byte lands in the next register, r7 wrapping to r0
                    regs[rd_q + 3'd1] <= res_hi;
                    done              <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                perf_count <= 16'h0000;
        else if (done && perf_count != 16'hFFFF) perf_count <= perf_count + 16'd1;
    end
`else
    assign perf_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed testbench for alu_issue_seq with a behavioural ALU model on the ALU-facing ports.
module tb_alu_issue_seq;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_op1;
    logic [7:0]  alu_op2;
    logic [15:0] alu_result;
    logic        alu_flagC;
    logic        alu_flagZ;
    logic        flag_c;
    logic        flag_z;
    logic        done;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_data;
    logic [15:0] perf_count;

    int checks = 0;
    int errors = 0;

    alu_issue_seq #(.REG_INIT(8'h00)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result), .alu_flagC(alu_flagC), .alu_flagZ(alu_flagZ),
        .flag_c(flag_c), .flag_z(flag_z), .done(done), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data), .perf_count(perf_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational ALU model
    always_comb begin
        alu_result = 16'h0000;
        alu_flagC  = 1'b0;
        case (alu_opcode)
            3'b000: begin
                alu_result = {8'h00, alu_op1} + {8'h00, alu_op2};
                alu_flagC  = alu_result[8];
            end
            3'b001: begin
                alu_result = {8'h00, alu_op1} - {8'h00, alu_op2};
                alu_flagC  = (alu_op1 < alu_op2);
            end
            3'b010:  alu_result = {8'h00, alu_op1} * {8'h00, alu_op2};
            3'b011:  alu_result = {8'h00, alu_op1 & alu_op2};
            3'b100:  alu_result = {8'h00, alu_op1 | alu_op2};
            3'b101:  alu_result = {8'h00, ~(alu_op1 & alu_op2)};
            3'b110:  alu_result = {8'h00, ~(alu_op1 | alu_op2)};
            default: alu_result = {8'h00, alu_op1 ^ alu_op2};
        endcase
        alu_flagZ = (alu_result == 16'h0000);
    end

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {1'b1, rd, 4'h0, imm};
    endfunction

    function automatic logic [15:0] aop(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        return {1'b0, op, rd, rs1, rs2, 3'b000};
    endfunction

    // driver tasks: called and return at a falling edge
    task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    task automatic issue(input logic [15:0] w);
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!instr_ready) begin
            errors++;
            $display("FAIL issue_timeout: instr_ready=%0b required 1 within 20 cycles", instr_ready);
        end
        instr       = w;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] d;
        checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || flag_c !== 1'b0 || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ready=%0b done=%0b c=%0b z=%0b required 1 0 0 0",
                     instr_ready, done, flag_c, flag_z);
        end
        checks++;
        if (alu_opcode !== 3'd0 || alu_op1 !== 8'd0 || alu_op2 !== 8'd0 || perf_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_alu_regs: opc=%0h op1=%0h op2=%0h perf=%0h required 0 0 0 0",
                     alu_opcode, alu_op1, alu_op2, perf_count);
        end
        // reset in the middle of EXEC
        issue(ldi(3'd1, 8'h55));
        issue(aop(3'b000, 3'd2, 3'd1, 3'd1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (instr_ready !== 1'b1 || done !== 1'b0 || flag_c !== 1'b0 || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_exec: ready=%0b done=%0b c=%0b z=%0b required 1 0 0 0",
                     instr_ready, done, flag_c, flag_z);
        end
        for (int i = 0; i < 8; i++) begin
            read_reg(i[2:0], d);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("FAIL reset_reg r%0d: got %02h required 00", i, d);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done=%0b required 0", done);
        end
    endtask

    task automatic test_add;
        logic [7:0] d;
        issue(ldi(3'd1, 8'hFF));
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL ldi_done: done=%0b required 1", done);
        end
        issue(ldi(3'd2, 8'h01));
        issue(aop(3'b000, 3'd3, 3'd1, 3'd2));
        checks++;
        if (done !== 1'b0 || instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_exec: done=%0b ready=%0b required 0 0", done, instr_ready);
        end
        @(negedge clk);
        read_reg(3'd3, d);
        checks++;
        if (done !== 1'b1 || instr_ready !== 1'b1 || d !== 8'h00 || flag_c !== 1'b1 || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL add_result: done=%0b ready=%0b r3=%02h c=%0b z=%0b required 1 1 00 1 0",
                     done, instr_ready, d, flag_c, flag_z);
        end
    endtask

    task automatic test_sub_xor;
        logic [7:0] d;
        issue(ldi(3'd4, 8'h03));
        issue(ldi(3'd5, 8'h05));
        issue(aop(3'b001, 3'd6, 3'd4, 3'd5));
        @(negedge clk);
        read_reg(3'd6, d);
        checks++;
        if (done !== 1'b1 || d !== 8'hFE || flag_c !== 1'b1 || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL sub_result: done=%0b r6=%02h c=%0b z=%0b required 1 fe 1 0",
                     done, d, flag_c, flag_z);
        end
        issue(aop(3'b111, 3'd0, 3'd6, 3'd6));
        @(negedge clk);
        read_reg(3'd0, d);
        checks++;
        if (done !== 1'b1 || d !== 8'h00 || flag_c !== 1'b1 || flag_z !== 1'b1) begin
            errors++;
            $display("FAIL xor_result: done=%0b r0=%02h c=%0b z=%0b required 1 00 1 1",
                     done, d, flag_c, flag_z);
        end
    endtask

    task automatic test_mul_wrap;
        logic [7:0] d7;
        logic [7:0] d0;
        issue(ldi(3'd1, 8'hC8));
        issue(ldi(3'd2, 8'h0A));
        issue(aop(3'b010, 3'd7, 3'd1, 3'd2));
        checks++;
        if (instr_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mul_exec: ready=%0b done=%0b required 0 0", instr_ready, done);
        end
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mul_wb_hi: ready=%0b done=%0b required 0 0", instr_ready, done);
        end
        @(negedge clk);
        read_reg(3'd7, d7);
        read_reg(3'd0, d0);
        checks++;
        if (done !== 1'b1 || instr_ready !== 1'b1 || d7 !== 8'hD0 || d0 !== 8'h07 ||
            flag_z !== 1'b0 || flag_c !== 1'b1) begin
            errors++;
            $display("FAIL mul_result: done=%0b ready=%0b r7=%02h r0=%02h z=%0b c=%0b required 1 1 d0 07 0 1",
                     done, instr_ready, d7, d0, flag_z, flag_c);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] words [5];
        logic [7:0]  d;
        words[0] = ldi(3'd1, 8'h0F);
        words[1] = ldi(3'd2, 8'h3C);
        words[2] = ldi(3'd3, 8'hAA);
        words[3] = ldi(3'd4, 8'h55);
        words[4] = aop(3'b011, 3'd5, 3'd1, 3'd2);
        instr       = words[0];
        instr_valid = 1'b1;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || instr_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ldi%0d: done=%0b ready=%0b required 1 1", i - 1, done, instr_ready);
            end
            instr = words[i];
        end
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || instr_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_and_exec: done=%0b ready=%0b required 0 0", done, instr_ready);
        end
        @(negedge clk);
        read_reg(3'd5, d);
        checks++;
        if (done !== 1'b1 || instr_ready !== 1'b1 || d !== 8'h0C || flag_c !== 1'b1 || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL b2b_and_result: done=%0b ready=%0b r5=%02h c=%0b z=%0b required 1 1 0c 1 0",
                     done, instr_ready, d, flag_c, flag_z);
        end
        read_reg(3'd4, d);
        checks++;
        if (d !== 8'h55) begin
            errors++;
            $display("FAIL b2b_r4: got %02h required 55", d);
        end
    endtask

    task automatic test_mul_overlap;
        logic [7:0] d0;
        logic [7:0] d1;
        // r0 = r1*r1 with r1 = 0x0F; high byte overwrites the source r1
        issue(aop(3'b010, 3'd0, 3'd1, 3'd1));
        @(negedge clk);
        @(negedge clk);
        read_reg(3'd0, d0);
        read_reg(3'd1, d1);
        checks++;
        if (done !== 1'b1 || d0 !== 8'hE1 || d1 !== 8'h00) begin
            errors++;
            $display("FAIL mul_overlap: done=%0b r0=%02h r1=%02h required 1 e1 00", done, d0, d1);
        end
    endtask

    task automatic test_perf;
        logic [15:0] exp_perf;
        @(negedge clk);
        @(negedge clk);
`ifdef ALU_SEQ_PERF_EN
        exp_perf = 16'd16;
`else
        exp_perf = 16'h0000;
`endif
        checks++;
        if (perf_count !== exp_perf) begin
            errors++;
            $display("FAIL perf_count: got %0d required %0d", perf_count, exp_perf);
        end
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dbg_addr    = 3'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_add;
        test_sub_xor;
        test_mul_wrap;
        test_back_to_back;
        test_mul_overlap;
        test_perf;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
